io_input_debounce: RTL and testbench
====================================

IO_INPUT_DEBOUNCE -- requirements
Module: io_input_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of consecutive cycles a synchronized input must differ from its stable value before the stable value updates; legal range 1..2^20.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 KEY_raw  input  4  asynchronous pushbutton levels, active-low (1 = released).
REQ-005 SW_raw  input  18  asynchronous slide-switch levels, active-high.
REQ-006 evt_clr  input  4  per-key acknowledge; a 1 in bit i clears key_event[i].
REQ-007 sw_clr  input  1  acknowledge; 1 clears sw_changed.
REQ-008 key_stable  output  4  debounced key state, active-high (1 = pressed).
REQ-009 sw_stable  output  18  debounced switch state.
REQ-010 key_event  output  4  sticky press flags, one per key.
REQ-011 evt_valid  output  1  OR-reduction of key_event.
REQ-012 sw_changed  output  1  sticky flag: some sw_stable bit changed since last clear.

Function
REQ-013 Each of the 22 raw bits SHALL pass through a two-flop synchronizer; only the second flop (sync2) feeds downstream logic.
REQ-014 Key bits SHALL be inverted after sync2, so every downstream key value is active-high.
REQ-015 Each bit SHALL have its own counter of width ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-016 Counter behaviour per bit:
- sync2 (polarity-corrected) equals stable: counter loads 0.
- Otherwise: counter increments.
- Counter reaching DEBOUNCE_CYCLES-1 while still differing: stable bit takes the sync2 value on that edge and the counter loads 0.
REQ-017 Latency: a raw level held constant from edge k onward SHALL appear on the stable output after edge k+1+DEBOUNCE_CYCLES (2 sync edges + DEBOUNCE_CYCLES).
REQ-018 A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 SHALL NOT change the stable output; its counter returns to 0 on the first agreeing cycle.
REQ-019 The counter SHALL never wrap; it saturates by construction per REQ-016.
REQ-020 key_event[i] SHALL set on the edge where key_stable[i] goes 0->1; a release (1->0) SHALL NOT set it.
REQ-021 key_event[i] SHALL clear on the edge after evt_clr[i]=1; if a set and a clear coincide, set wins.
REQ-022 evt_clr bits for keys whose event flag is 0 SHALL have no effect.
REQ-023 sw_changed SHALL set on any edge where one or more sw_stable bits change value; sw_clr clears it; set wins on coincidence.
REQ-024 evt_valid SHALL be combinational from the key_event registers, with no extra latency.
REQ-025 Outputs SHALL be registered except evt_valid; there are no combinational raw-to-output paths.

Reset
REQ-026 While rst=1 at a rising edge:
- Key synchronizer flops load 1 (released).
- Switch synchronizer flops load 0.
- All counters load 0.
- key_stable, sw_stable, key_event, sw_changed load 0; evt_valid is therefore 0.
REQ-027 rst asserted mid-debounce SHALL discard partial counts.
- After rst deasserts, a raw level already held SHALL take the full REQ-017 latency to reach the stable output.
- A switch held at 1 through reset SHALL then set sw_changed on its transition.
REQ-028 rst SHALL take priority over evt_clr, sw_clr and all set conditions.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-029 Reset, KEY_raw=4'b1111, SW_raw=0 -> all outputs 0 for 20 cycles.
REQ-030 KEY_raw[0] driven 0 at edge k and held -> key_stable=4'b0001 and key_event=4'b0001 after edge k+5, evt_valid=1; neither changes earlier.
REQ-031 KEY_raw[1] low for 3 cycles, then high -> key_stable[1] and key_event[1] remain 0 throughout.
REQ-032 key_event[2] set, then evt_clr=4'b0100 for 1 cycle -> key_event=0 next edge; repeat with a new press completing on the same edge as evt_clr -> key_event[2] stays 1.
REQ-033 SW_raw=18'h00001 held -> sw_stable=18'h00001 and sw_changed=1 after 5 edges from the change; sw_clr pulse -> sw_changed=0; SW_raw unchanged -> sw_changed stays 0.
REQ-034 SW_raw[3] raised, rst pulsed 3 cycles later, then released -> sw_stable=0 immediately after reset; sw_stable[3]=1 exactly 5 edges after rst deasserts.

Source files
------------

// File: rtl/io_input_debounce.sv
// Debouncer for 4 active-low pushbuttons and 18 slide switches: two-flop sync,
// per-bit hold counter, sticky key-press and switch-change flags.
module io_input_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  KEY_raw,
    input  logic [17:0] SW_raw,
    input  logic [3:0]  evt_clr,
    input  logic        sw_clr,
    output logic [3:0]  key_stable,
    output logic [17:0] sw_stable,
    output logic [3:0]  key_event,
    output logic        evt_valid,
    output logic        sw_changed
);

    localparam int NB = 22;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    key_sync1, key_sync2;
    logic [17:0]   sw_sync1, sw_sync2;
    logic [NB-1:0] level;
    logic [NB-1:0] stable;
    logic [NB-1:0] next_stable;
    logic [CW-1:0] cnt      [NB];
    logic [CW-1:0] next_cnt [NB];

    // Keys are flipped to active-high here so every bit downstream is uniform.
    assign level = {sw_sync2, ~key_sync2};

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_stable = stable;
        for (int i = 0; i < NB; i++) begin
            next_cnt[i] = '0;
            if (level[i] != stable[i]) begin
                if (cnt[i] == LAST) next_stable[i] = level[i];
                else                next_cnt[i]    = cnt[i] + CW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_sync1  <= '1;
            key_sync2  <= '1;
            sw_sync1   <= '0;
            sw_sync2   <= '0;
            stable     <= '0;
            key_event  <= '0;
            sw_changed <= 1'b0;
            // Counters are cleared too so a partial count never survives reset.
            for (int i = 0; i < NB; i++) cnt[i] <= '0;
        end else begin
            key_sync1  <= KEY_raw;
            key_sync2  <= key_sync1;
            sw_sync1   <= SW_raw;
            sw_sync2   <= sw_sync1;
            stable     <= next_stable;
            for (int i = 0; i < NB; i++) cnt[i] <= next_cnt[i];
            // Set terms are OR-ed in after the clear so a coincident set wins.
            key_event  <= (key_event & ~evt_clr) | (next_stable[3:0] & ~stable[3:0]);
            sw_changed <= (sw_changed & ~sw_clr) | (next_stable[NB-1:4] != stable[NB-1:4]);
        end
    end

    assign key_stable = stable[3:0];
    assign sw_stable  = stable[NB-1:4];
    assign evt_valid  = |key_event;

endmodule

// File: tb/tb_io_input_debounce.sv
// Randomized scoreboard bench for io_input_debounce with DEBOUNCE_CYCLES=4:
// a window-based reference model predicts outputs, a monitor compares them.
module tb_io_input_debounce;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  KEY_raw;
    logic [17:0] SW_raw;
    logic [3:0]  evt_clr;
    logic        sw_clr;
    logic [3:0]  key_stable;
    logic [17:0] sw_stable;
    logic [3:0]  key_event;
    logic        evt_valid;
    logic        sw_changed;

    io_input_debounce #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .KEY_raw(KEY_raw), .SW_raw(SW_raw),
        .evt_clr(evt_clr), .sw_clr(sw_clr), .key_stable(key_stable),
        .sw_stable(sw_stable), .key_event(key_event), .evt_valid(evt_valid),
        .sw_changed(sw_changed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  key_stable;
        logic [17:0] sw_stable;
        logic [3:0]  key_event;
        logic        evt_valid;
        logic        sw_changed;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   done     = 1'b0;

    // Model history, indexed by edge number: reset flag and polarity-corrected raw sample.
    bit          rst_h [int];
    logic [21:0] raw_h [int];
    int          t = 0;
    logic [21:0] m_stable = '0;
    logic [3:0]  m_kev = '0;
    logic        m_swc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Value the debounce logic compares at edge e: the raw sample two edges back,
    // or the reset default if either synchronizer stage was reset in between.
    function automatic logic [21:0] seen_at(input int e);
        if (e < 2 || rst_h[e-1] || rst_h[e-2]) return '0;
        return raw_h[e-2];
    endfunction

    // A bit flips when the last D non-reset comparisons all disagree with it.
    task automatic model_step(input logic [3:0] ec, input logic sc);
        logic [21:0] ns;
        if (rst_h[t]) begin
            m_stable = '0;
            m_kev    = '0;
            m_swc    = 1'b0;
            return;
        end
        ns = m_stable;
        for (int b = 0; b < 22; b++) begin
            bit flip = 1'b1;
            for (int j = 0; j < D; j++) begin
                int e = t - j;
                logic [21:0] s;
                if (e < 0 || rst_h[e]) begin flip = 1'b0; break; end
                s = seen_at(e);
                if (s[b] == m_stable[b]) begin flip = 1'b0; break; end
            end
            if (flip) ns[b] = ~m_stable[b];
        end
        m_kev    = (m_kev & ~ec) | (ns[3:0] & ~m_stable[3:0]);
        m_swc    = (m_swc & ~sc) | (ns[21:4] != m_stable[21:4]);
        m_stable = ns;
    endtask

    task automatic cycle(input bit r, input logic [3:0] k, input logic [17:0] s,
                         input logic [3:0] ec, input logic sc);
        exp_t x;
        rst = r; KEY_raw = k; SW_raw = s; evt_clr = ec; sw_clr = sc;
        rst_h[t] = r;
        raw_h[t] = {s, ~k};
        model_step(ec, sc);
        x.key_stable = m_stable[3:0];
        x.sw_stable  = m_stable[21:4];
        x.key_event  = m_kev;
        x.evt_valid  = |m_kev;
        x.sw_changed = m_swc;
        exp_q.push_back(x);
        t++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL queue_empty @%0t: got no expectation, required one", $time);
            end else begin
                x = exp_q.pop_front();
                check("key_stable", 32'(key_stable), 32'(x.key_stable));
                check("sw_stable",  32'(sw_stable),  32'(x.sw_stable));
                check("key_event",  32'(key_event),  32'(x.key_event));
                check("evt_valid",  32'(evt_valid),  32'(x.evt_valid));
                check("sw_changed", 32'(sw_changed), 32'(x.sw_changed));
            end
        end
    end

    initial begin : stimulus
        logic [3:0]  k;
        logic [17:0] s;
        for (int i = 0; i < 3; i++)  cycle(1, 4'hF, '0, '0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 4'hF, '0, '0, 0);
        // Key 0 press held; key 1 short glitch.
        for (int i = 0; i < 10; i++) cycle(0, 4'hE, '0, '0, 0);
        for (int i = 0; i < 3; i++)  cycle(0, 4'hC, '0, '0, 0);
        for (int i = 0; i < 8; i++)  cycle(0, 4'hE, '0, '0, 0);
        // Key 2: press, acknowledge, release, re-press completing with a clear.
        for (int i = 0; i < 8; i++)  cycle(0, 4'hA, '0, '0, 0);
        cycle(0, 4'hA, '0, 4'b0100, 0);
        for (int i = 0; i < 2; i++)  cycle(0, 4'hA, '0, '0, 0);
        for (int i = 0; i < 8; i++)  cycle(0, 4'hE, '0, '0, 0);
        for (int i = 0; i < 5; i++)  cycle(0, 4'hA, '0, '0, 0);
        cycle(0, 4'hA, '0, 4'b0100, 0);
        for (int i = 0; i < 3; i++)  cycle(0, 4'hA, '0, '0, 0);
        // Switch 0 change, acknowledge, quiet.
        for (int i = 0; i < 8; i++)  cycle(0, 4'hF, 18'h00001, '0, 0);
        cycle(0, 4'hF, 18'h00001, '0, 1);
        for (int i = 0; i < 4; i++)  cycle(0, 4'hF, 18'h00001, '0, 0);
        // Switch 3 raised, reset mid-debounce, then settles.
        for (int i = 0; i < 3; i++)  cycle(0, 4'hF, 18'h00009, '0, 0);
        cycle(1, 4'hF, 18'h00009, '0, 0);
        for (int i = 0; i < 8; i++)  cycle(0, 4'hF, 18'h00009, '0, 0);
        // Randomized phase: slowly flipping levels, random acks and rare resets.
        k = 4'hF;
        s = 18'h00009;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++)  if ($urandom_range(0, 5) == 0) k[b] = ~k[b];
            for (int b = 0; b < 18; b++) if ($urandom_range(0, 7) == 0) s[b] = ~s[b];
            cycle($urandom_range(0, 199) == 0, k, s,
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                  $urandom_range(0, 7) == 0);
        end
        done = 1'b1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL leftover: got %0d unchecked expectations, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
